// File: rtl/uart_rx.sv
// UART receive stage: 8N1-style frames, LSB first, packed NUM_WORDS at a time
// into one W_OUT-bit beat presented on a valid/ready master port.
module uart_rx #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [W_OUT-1:0] m_data,
  output logic             frame_err,
  output logic             overrun
);

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int HALF      = CLOCKS_PER_PULSE / 2;
  localparam int CW        = ($clog2(CLOCKS_PER_PULSE) < 1) ? 1 : $clog2(CLOCKS_PER_PULSE);
  localparam int BW        = ($clog2(BITS_PER_WORD) < 1) ? 1 : $clog2(BITS_PER_WORD);
  localparam int WW        = ($clog2(NUM_WORDS) < 1) ? 1 : $clog2(NUM_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic                     r_sync1;
  logic                     r_sync2;
  logic [1:0]               r_state;
  logic [CW-1:0]            r_c_clocks;
  logic [BW-1:0]            r_c_bits;
  logic [WW-1:0]            r_c_words;
  logic [BITS_PER_WORD-1:0] r_shift;
  logic [BITS_PER_WORD-1:0] r_slots [NUM_WORDS];
  logic                     r_valid;
  logic [W_OUT-1:0]         r_data;
  logic                     r_ferr;
  logic                     r_ovr;

  logic                     w_rx_s;
  logic                     w_bit_end;
  logic                     w_stop_sample;
  logic                     w_beat_done;
  logic [W_OUT-1:0]         w_beat;

  assign w_rx_s        = r_sync2;
  assign w_bit_end     = (r_c_clocks == CW'(CLOCKS_PER_PULSE - 1));
  assign w_stop_sample = (r_state == S_STOP) && w_bit_end;
  assign w_beat_done   = w_stop_sample && w_rx_s && (r_c_words == WW'(NUM_WORDS - 1));

  // On completion the last word is still in the shift register, not yet in a slot.
  always_comb begin
    w_beat = '0;
    for (int unsigned i = 0; i < NUM_WORDS - 1; i++) begin
      w_beat[i*BITS_PER_WORD +: BITS_PER_WORD] = r_slots[i];
    end
    w_beat[(NUM_WORDS-1)*BITS_PER_WORD +: BITS_PER_WORD] = r_shift;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_c_clocks <= '0;
      r_c_bits   <= '0;
      r_c_words  <= '0;
      r_shift    <= '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state    <= S_START;
            r_c_clocks <= '0;
          end
        end
        S_START: begin
          if (r_c_clocks == CW'(HALF - 1)) begin
            if (!w_rx_s) begin
              r_state    <= S_DATA;
              r_c_clocks <= '0;
              r_c_bits   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_c_clocks <= r_c_clocks + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_c_clocks <= '0;
            r_shift    <= {w_rx_s, r_shift[BITS_PER_WORD-1:1]};
            if (r_c_bits == BW'(BITS_PER_WORD - 1)) begin
              r_state <= S_STOP;
            end else begin
              r_c_bits <= r_c_bits + BW'(1);
            end
          end else begin
            r_c_clocks <= r_c_clocks + CW'(1);
          end
        end
        default: begin
          if (w_bit_end) begin
            r_c_clocks <= '0;
            r_state    <= S_IDLE;
            if (w_rx_s) begin
              r_slots[r_c_words] <= r_shift;
              if (r_c_words == WW'(NUM_WORDS - 1)) begin
                r_c_words <= '0;
              end else begin
                r_c_words <= r_c_words + WW'(1);
              end
            end else begin
              r_c_words <= '0;
            end
          end else begin
            r_c_clocks <= r_c_clocks + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_sample && !w_rx_s;
      r_ovr  <= w_beat_done && r_valid && !m_ready;
      if (w_beat_done && (!r_valid || m_ready)) begin
        r_valid <= 1'b1;
        r_data  <= w_beat;
      end else if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_valid   = r_valid;
  assign m_data    = r_data;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule
